// File: rtl/multi_cycle_cu_pkg.sv
// +--------------------------------------------------------------------------+
// | multi_cycle_cu_pkg : opcodes, FSM states, ALU/PC codes, decoded controls |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package multi_cycle_cu_pkg;

  // Nine phases do not fit in three bits, so the state register is four wide.
  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EXE_AL = 4'd2,
    S_EXE_BR = 4'd3,
    S_EXE_LS = 4'd4,
    S_MEM    = 4'd5,
    S_WB_AL  = 4'd6,
    S_WB_LD  = 4'd7,
    S_HALT   = 4'd8
  } state_e;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_ORI  = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_OR   = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_SLTI = 6'b011011;
  localparam logic [5:0] OP_SW   = 6'b100110;
  localparam logic [5:0] OP_LW   = 6'b100111;
  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_BNE  = 6'b110001;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b110;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  typedef enum logic [2:0] {
    C_NOP  = 3'd0,
    C_ALU  = 3'd1,
    C_BR   = 3'd2,
    C_LW   = 3'd3,
    C_SW   = 3'd4,
    C_J    = 3'd5,
    C_HALT = 3'd6
  } iclass_e;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       ext_sel;
    logic       reg_dst;
    logic       db_data_src;
    logic       is_bne;
  } ctl_t;

endpackage

`default_nettype wire

// File: rtl/multi_cycle_cu_decode.sv
// +--------------------------------------------------------------------------+
// | multi_cycle_cu_decode : opCode -> instruction class and static controls  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module multi_cycle_cu_decode
  import multi_cycle_cu_pkg::*;
(
  input  logic [5:0] opCode_i,
  output iclass_e    cls_o,
  output ctl_t       ctl_o
);

  always_comb begin
    cls_o         = C_NOP;
    ctl_o         = '0;
    ctl_o.ext_sel = 1'b1;
    case (opCode_i)
      OP_ADD: begin
        cls_o         = C_ALU;
        ctl_o.alu_op  = ALU_ADD;
        ctl_o.reg_dst = 1'b1;
      end
      OP_ADDI: begin
        cls_o           = C_ALU;
        ctl_o.alu_op    = ALU_ADD;
        ctl_o.alu_src_b = 1'b1;
      end
      OP_SUB: begin
        cls_o         = C_ALU;
        ctl_o.alu_op  = ALU_SUB;
        ctl_o.reg_dst = 1'b1;
      end
      OP_ORI: begin
        cls_o           = C_ALU;
        ctl_o.alu_op    = ALU_OR;
        ctl_o.alu_src_b = 1'b1;
        ctl_o.ext_sel   = 1'b0;
      end
      OP_AND: begin
        cls_o         = C_ALU;
        ctl_o.alu_op  = ALU_AND;
        ctl_o.reg_dst = 1'b1;
      end
      OP_OR: begin
        cls_o         = C_ALU;
        ctl_o.alu_op  = ALU_OR;
        ctl_o.reg_dst = 1'b1;
      end
      OP_SLL: begin
        cls_o           = C_ALU;
        ctl_o.alu_op    = ALU_SLL;
        ctl_o.alu_src_a = 1'b1;
        ctl_o.reg_dst   = 1'b1;
      end
      OP_SLTI: begin
        cls_o           = C_ALU;
        ctl_o.alu_op    = ALU_SLT;
        ctl_o.alu_src_b = 1'b1;
      end
      OP_SW: begin
        cls_o           = C_SW;
        ctl_o.alu_op    = ALU_ADD;
        ctl_o.alu_src_b = 1'b1;
      end
      OP_LW: begin
        cls_o             = C_LW;
        ctl_o.alu_op      = ALU_ADD;
        ctl_o.alu_src_b   = 1'b1;
        ctl_o.db_data_src = 1'b1;
      end
      OP_BEQ: begin
        cls_o        = C_BR;
        ctl_o.alu_op = ALU_SUB;
      end
      OP_BNE: begin
        cls_o        = C_BR;
        ctl_o.alu_op = ALU_SUB;
        ctl_o.is_bne = 1'b1;
      end
      OP_J:    cls_o = C_J;
      OP_HALT: cls_o = C_HALT;
      default: cls_o = C_NOP;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multi_cycle_cu.sv
// +--------------------------------------------------------------------------+
// | multi_cycle_cu : IF/ID/EXE/MEM/WB control FSM with retired-instr counter |
// | Option MEM_WAIT_EN: MEM stalls until memReady.            Rev 1.0        |
// +--------------------------------------------------------------------------+
`default_nettype none

module multi_cycle_cu
  import multi_cycle_cu_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int STATE_W = multi_cycle_cu_pkg::STATE_W
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [5:0]         opCode,
  input  logic               zero,
  input  logic               memReady,
  output logic               PCWre,
  output logic               IRWre,
  output logic               InsMemRW,
  output logic               ExtSel,
  output logic               RegDst,
  output logic               RegWre,
  output logic [2:0]         ALUOp,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic [1:0]         PCSrc,
  output logic               mRD,
  output logic               mWR,
  output logic               DBDataSrc,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   instCount
);

  state_e           state_q, state_d;
  iclass_e          id_cls, cls_q;
  ctl_t             id_ctl, ctl_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mem_done;
  logic             br_taken;

  multi_cycle_cu_decode u_decode (
    .opCode_i (opCode),
    .cls_o    (id_cls),
    .ctl_o    (id_ctl)
  );

`ifdef MEM_WAIT_EN
  assign mem_done = memReady;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = memReady;
  assign mem_done         = 1'b1;
`endif

  assign br_taken = ctl_q.is_bne ? ~zero : zero;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        case (id_cls)
          C_ALU:       state_d = S_EXE_AL;
          C_BR:        state_d = S_EXE_BR;
          C_LW, C_SW:  state_d = S_EXE_LS;
          C_HALT:      state_d = S_HALT;
          default:     state_d = S_IF;
        endcase
      end
      S_EXE_AL: state_d = S_WB_AL;
      S_EXE_BR: state_d = S_IF;
      S_EXE_LS: state_d = S_MEM;
      S_MEM: begin
        if (mem_done) state_d = (cls_q == C_LW) ? S_WB_LD : S_IF;
      end
      S_WB_AL, S_WB_LD: state_d = S_IF;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  // Enables are gated by Reset so they drop the moment reset asserts.
  always_comb begin
    PCWre  = 1'b0;
    IRWre  = 1'b0;
    RegWre = 1'b0;
    mRD    = 1'b0;
    mWR    = 1'b0;
    PCSrc  = PC_SEQ;
    if (Reset) begin
      case (state_q)
        S_IF: IRWre = 1'b1;
        S_ID: begin
          if (id_cls == C_J || id_cls == C_NOP) PCWre = 1'b1;
          if (id_cls == C_J) PCSrc = PC_JMP;
        end
        S_EXE_BR: begin
          PCWre = 1'b1;
          PCSrc = br_taken ? PC_BR : PC_SEQ;
        end
        S_MEM: begin
          mRD   = (cls_q == C_LW);
          mWR   = (cls_q == C_SW);
          PCWre = (cls_q == C_SW) & mem_done;
        end
        S_WB_AL, S_WB_LD: begin
          RegWre = 1'b1;
          PCWre  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Static controls are captured at the end of ID and held through WB.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IF;
      cls_q   <= C_NOP;
      ctl_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ID) begin
        cls_q <= id_cls;
        ctl_q <= id_ctl;
      end
      if (PCWre) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign InsMemRW  = 1'b0;
  assign ALUOp     = ctl_q.alu_op;
  assign ALUSrcA   = ctl_q.alu_src_a;
  assign ALUSrcB   = ctl_q.alu_src_b;
  assign ExtSel    = ctl_q.ext_sel;
  assign RegDst    = ctl_q.reg_dst;
  assign DBDataSrc = ctl_q.db_data_src;
  assign state     = STATE_W'(state_q);
  assign instCount = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_multi_cycle_cu.sv
// +--------------------------------------------------------------------------+
// | tb_multi_cycle_cu : random instruction stream vs. phase/latency model    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_multi_cycle_cu;
  import multi_cycle_cu_pkg::*;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [5:0]  opCode;
  logic        zero;
  logic        memReady;

  logic        PCWre, IRWre, InsMemRW, ExtSel, RegDst, RegWre;
  logic [2:0]  ALUOp;
  logic        ALUSrcA, ALUSrcB, mRD, mWR, DBDataSrc;
  logic [1:0]  PCSrc;
  logic [3:0]  state;
  logic [15:0] instCount;

  logic        d4_PCWre, d4_IRWre, d4_InsMemRW, d4_ExtSel, d4_RegDst, d4_RegWre;
  logic [2:0]  d4_ALUOp;
  logic        d4_ALUSrcA, d4_ALUSrcB, d4_mRD, d4_mWR, d4_DBDataSrc;
  logic [1:0]  d4_PCSrc;
  logic [3:0]  d4_state;
  logic [3:0]  d4_instCount;

  multi_cycle_cu u_dut (
    .CLK(CLK), .Reset(Reset), .opCode(opCode), .zero(zero), .memReady(memReady),
    .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .ExtSel(ExtSel),
    .RegDst(RegDst), .RegWre(RegWre), .ALUOp(ALUOp), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .mRD(mRD), .mWR(mWR),
    .DBDataSrc(DBDataSrc), .state(state), .instCount(instCount)
  );

  multi_cycle_cu #(.CNT_W(4)) u_dut4 (
    .CLK(CLK), .Reset(Reset), .opCode(opCode), .zero(zero), .memReady(memReady),
    .PCWre(d4_PCWre), .IRWre(d4_IRWre), .InsMemRW(d4_InsMemRW), .ExtSel(d4_ExtSel),
    .RegDst(d4_RegDst), .RegWre(d4_RegWre), .ALUOp(d4_ALUOp), .ALUSrcA(d4_ALUSrcA),
    .ALUSrcB(d4_ALUSrcB), .PCSrc(d4_PCSrc), .mRD(d4_mRD), .mWR(d4_mWR),
    .DBDataSrc(d4_DBDataSrc), .state(d4_state), .instCount(d4_instCount)
  );

  always #5 CLK = ~CLK;

  typedef enum {K_NOP, K_ALU, K_BR, K_LW, K_SW, K_J, K_HALT} kind_t;
  typedef enum {P_IF, P_ID, P_EXE, P_MEM, P_WB} phase_t;
  typedef struct {
    logic [5:0] op;
    kind_t      k;
    logic [2:0] aluop;
    bit         srca;
    bit         srcb;
    bit         db;
    int         regdst;
    int         ext;
  } ispec_t;

  ispec_t tbl[14];
  int     n_checks = 0;
  int     n_pass   = 0;
  int     exp_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic ispec_t mk(input logic [5:0] op, input kind_t k, input logic [2:0] aluop,
                                input bit srca, input bit srcb, input bit db,
                                input int regdst, input int ext);
    ispec_t s;
    s.op = op; s.k = k; s.aluop = aluop; s.srca = srca; s.srcb = srcb;
    s.db = db; s.regdst = regdst; s.ext = ext;
    return s;
  endfunction

  function automatic int find(input logic [5:0] op);
    for (int i = 0; i < 14; i++) if (tbl[i].op == op) return i;
    return -1;
  endfunction

  function automatic int latency(input kind_t k);
    case (k)
      K_ALU:   return 4;
      K_LW:    return 5;
      K_SW:    return 4;
      K_BR:    return 3;
      default: return 2;
    endcase
  endfunction

  function automatic phase_t phase_at(input kind_t k, input int pos);
    if (pos == 0) return P_IF;
    if (pos == 1) return P_ID;
    if (pos == 2) return P_EXE;
    if (pos == 3 && (k == K_LW || k == K_SW)) return P_MEM;
    return P_WB;
  endfunction

  function automatic state_e state_of(input phase_t p, input kind_t k);
    case (p)
      P_IF:    return S_IF;
      P_ID:    return S_ID;
      P_EXE:   return (k == K_ALU) ? S_EXE_AL : (k == K_BR) ? S_EXE_BR : S_EXE_LS;
      P_MEM:   return S_MEM;
      default: return (k == K_LW) ? S_WB_LD : S_WB_AL;
    endcase
  endfunction

  task automatic check_counts(input string tag);
    check({tag, "_cnt"},  32'(instCount),    exp_cnt & 32'hFFFF);
    check({tag, "_cnt4"}, 32'(d4_instCount), exp_cnt & 32'hF);
  endtask

  // zf < 0 drives a random zero flag; otherwise zero is forced to zf.
  task automatic run_instr(input logic [5:0] op, input int zf, input bit abort_in_mem);
    int     idx = find(op);
    kind_t  k   = (idx < 0) ? K_NOP : tbl[idx].k;
    int     len = latency(k);
    int     pos = 0;
    phase_t p;
    bit     stall, last, taken, e_pcwre;
    logic [1:0] e_pcsrc;
    opCode = op;
    while (pos < len) begin
      zero     = (zf < 0) ? 1'($urandom_range(0, 1)) : 1'(zf);
      memReady = 1'($urandom_range(0, 1));
      #1;
      p     = phase_at(k, pos);
      stall = 1'b0;
`ifdef MEM_WAIT_EN
      if (p == P_MEM && !memReady) stall = 1'b1;
`endif
      last    = (pos == len - 1) && (k != K_HALT);
      taken   = (op == 6'b110000) ? zero : !zero;
      e_pcwre = last && !stall;
      e_pcsrc = (p == P_ID && k == K_J) ? 2'b10 :
                (p == P_EXE && k == K_BR && taken) ? 2'b01 : 2'b00;
      check("PCWre",    32'(PCWre),    32'(e_pcwre));
      check("IRWre",    32'(IRWre),    32'(p == P_IF));
      check("RegWre",   32'(RegWre),   32'(p == P_WB));
      check("mRD",      32'(mRD),      32'(p == P_MEM && k == K_LW));
      check("mWR",      32'(mWR),      32'(p == P_MEM && k == K_SW));
      check("PCSrc",    32'(PCSrc),    32'(e_pcsrc));
      check("InsMemRW", 32'(InsMemRW), 32'(0));
      check("state",    32'(state),    32'(state_of(p, k)));
      check_counts("run");
      if (idx >= 0 && (p == P_EXE || p == P_MEM || p == P_WB)) begin
        check("ALUOp",     32'(ALUOp),     32'(tbl[idx].aluop));
        check("ALUSrcA",   32'(ALUSrcA),   32'(tbl[idx].srca));
        check("ALUSrcB",   32'(ALUSrcB),   32'(tbl[idx].srcb));
        check("DBDataSrc", 32'(DBDataSrc), 32'(tbl[idx].db));
        if (tbl[idx].regdst >= 0) check("RegDst", 32'(RegDst), tbl[idx].regdst);
        if (tbl[idx].ext >= 0)    check("ExtSel", 32'(ExtSel), tbl[idx].ext);
      end
      if (abort_in_mem && p == P_MEM) begin
        #1 Reset = 1'b0;
        #1;
        check("rst_PCWre",  32'(PCWre),  32'(0));
        check("rst_IRWre",  32'(IRWre),  32'(0));
        check("rst_RegWre", 32'(RegWre), 32'(0));
        check("rst_mRD",    32'(mRD),    32'(0));
        check("rst_mWR",    32'(mWR),    32'(0));
        check("rst_PCSrc",  32'(PCSrc),  32'(0));
        check("rst_ALUOp",  32'(ALUOp),  32'(0));
        check("rst_state",  32'(state),  32'(S_IF));
        exp_cnt = 0;
        check_counts("rst");
        #1 Reset = 1'b1;
        return;
      end
      if (e_pcwre) exp_cnt++;
      @(posedge CLK);
      #1;
      if (!stall) pos++;
    end
    if (k == K_HALT) begin
      for (int c = 0; c < 20; c++) begin
        zero     = 1'($urandom_range(0, 1));
        memReady = 1'($urandom_range(0, 1));
        #1;
        check("halt_state", 32'(state), 32'(S_HALT));
        check("halt_PCWre", 32'(PCWre), 32'(0));
        check("halt_IRWre", 32'(IRWre), 32'(0));
        check_counts("halt");
        @(posedge CLK);
        #1;
      end
    end
  endtask

  function automatic logic [5:0] random_op();
    logic [5:0] op;
    if ($urandom_range(0, 3) != 0) return tbl[$urandom_range(0, 12)].op;
    do op = 6'($urandom_range(0, 63)); while (find(op) >= 0);
    return op;
  endfunction

  initial begin
    tbl[0]  = mk(6'b000000, K_ALU,  3'b000, 0, 0, 0,  1, -1);
    tbl[1]  = mk(6'b000001, K_ALU,  3'b000, 0, 1, 0,  0,  1);
    tbl[2]  = mk(6'b000010, K_ALU,  3'b001, 0, 0, 0,  1, -1);
    tbl[3]  = mk(6'b010000, K_ALU,  3'b011, 0, 1, 0,  0,  0);
    tbl[4]  = mk(6'b010001, K_ALU,  3'b100, 0, 0, 0,  1, -1);
    tbl[5]  = mk(6'b010010, K_ALU,  3'b011, 0, 0, 0,  1, -1);
    tbl[6]  = mk(6'b011000, K_ALU,  3'b010, 1, 0, 0,  1, -1);
    tbl[7]  = mk(6'b011011, K_ALU,  3'b110, 0, 1, 0,  0,  1);
    tbl[8]  = mk(6'b100110, K_SW,   3'b000, 0, 1, 0, -1,  1);
    tbl[9]  = mk(6'b100111, K_LW,   3'b000, 0, 1, 1,  0,  1);
    tbl[10] = mk(6'b110000, K_BR,   3'b001, 0, 0, 0, -1,  1);
    tbl[11] = mk(6'b110001, K_BR,   3'b001, 0, 0, 0, -1,  1);
    tbl[12] = mk(6'b111000, K_J,    3'b000, 0, 0, 0, -1, -1);
    tbl[13] = mk(6'b111111, K_HALT, 3'b000, 0, 0, 0, -1, -1);

    Reset    = 1'b0;
    opCode   = 6'b0;
    zero     = 1'b0;
    memReady = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("init_state", 32'(state),  32'(S_IF));
    check("init_IRWre", 32'(IRWre),  32'(0));
    check("init_PCWre", 32'(PCWre),  32'(0));
    check("init_ALUOp", 32'(ALUOp),  32'(0));
    check_counts("init");
    Reset = 1'b1;

    run_instr(6'b000001, -1, 1'b0);   // addi
    run_instr(6'b100111, -1, 1'b0);   // lw
    run_instr(6'b100110, -1, 1'b0);   // sw
    run_instr(6'b110000,  1, 1'b0);   // beq taken
    run_instr(6'b110000,  0, 1'b0);   // beq not taken
    run_instr(6'b110001,  1, 1'b0);   // bne not taken
    run_instr(6'b110001,  0, 1'b0);   // bne taken
    run_instr(6'b111000, -1, 1'b0);   // j
    run_instr(6'b011000, -1, 1'b0);   // sll
    run_instr(6'b101010, -1, 1'b0);   // undefined -> NOP
    run_instr(6'b100111, -1, 1'b1);   // lw interrupted by reset in MEM
    for (int i = 0; i < 17; i++) run_instr(6'b111000, -1, 1'b0);
    for (int i = 0; i < 300; i++) run_instr(random_op(), -1, 1'b0);
    run_instr(6'b111111, -1, 1'b0);   // halt

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
